// File: rtl/adc_scan_scheduler.sv
// ADC scan scheduler: sequences one-at-a-time conversions over the enabled
// channels in ascending order, on a periodic timer or on a single request.
// Ports:
//   clk, rst                 clock, async active-high reset
//   scan_enable, single_scan periodic enable level, one-shot request pulse
//   ch_mask, err_clear       channel enables, sticky-error clear pulse
//   conv_start, conv_ch      conversion request pulse and channel
//   conv_done, conv_data     conversion completion pulse and result
//   ch_data, ch_valid        per-channel results and valid flags
//   scan_done, scan_count    end-of-scan pulse, wrapping scan counter
//   busy, scan_pending       FSM active, request queued
//   timeout_err, err_ch      sticky timeout flag, last timed-out channel
module adc_scan_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 2,
    parameter int DATA_W       = 16,
    parameter int SCAN_PERIOD  = 10000,
    parameter int CONV_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scan_enable,
    input  logic                     single_scan,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic                     err_clear,
    output logic                     conv_start,
    output logic [CH_W-1:0]          conv_ch,
    input  logic                     conv_done,
    input  logic [DATA_W-1:0]        conv_data,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic                     scan_done,
    output logic [7:0]               scan_count,
    output logic                     busy,
    output logic                     scan_pending,
    output logic                     timeout_err,
    output logic [CH_W-1:0]          err_ch
);

    localparam int PER_W = $clog2(SCAN_PERIOD);
    localparam int TO_W  = $clog2(CONV_TIMEOUT + 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SCAN_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(CONV_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [PER_W-1:0]         r_period, w_period_nxt;
    logic                     w_period_wrap;
    logic                     r_pending, w_pend_nxt, w_pend_take;
    logic [NUM_CH-1:0]        r_snap, w_snap_nxt;
    logic [TO_W-1:0]          r_to_cnt, w_to_nxt;
    logic                     r_conv_start, w_start_nxt;
    logic [CH_W-1:0]          r_conv_ch, w_ch_nxt;
    logic [NUM_CH*DATA_W-1:0] r_ch_data, w_data_nxt;
    logic [NUM_CH-1:0]        r_ch_valid, w_valid_nxt;
    logic                     r_scan_done, w_done_nxt;
    logic [7:0]               r_scan_count, w_cnt_nxt;
    logic                     r_timeout_err, w_err_nxt;
    logic [CH_W-1:0]          r_err_ch, w_errch_nxt;
    logic [CH_W-1:0]          w_lowest;
    logic [CH_W-1:0]          w_above;
    logic                     w_has_above;

    // Lowest enabled channel in the live mask (used at snapshot time).
    always_comb begin
        w_lowest = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) w_lowest = CH_W'(i);
        end
    end

    // Next enabled channel above the current one in the snapshot.
    always_comb begin
        w_above     = '0;
        w_has_above = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_snap[i] && i > int'(r_conv_ch)) begin
                w_above     = CH_W'(i);
                w_has_above = 1'b1;
            end
        end
    end

    always_comb begin
        w_period_wrap = 1'b0;
        w_period_nxt  = '0;
        if (scan_enable) begin
            if (r_period == PER_LAST) w_period_wrap = 1'b1;
            else w_period_nxt = r_period + PER_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_take = 1'b0;
        w_snap_nxt  = r_snap;
        w_to_nxt    = r_to_cnt;
        w_start_nxt = 1'b0;
        w_ch_nxt    = r_conv_ch;
        w_data_nxt  = r_ch_data;
        w_valid_nxt = r_ch_valid;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_scan_count;
        w_err_nxt   = r_timeout_err & ~err_clear;
        w_errch_nxt = r_err_ch;
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_pend_take = 1'b1;
                    w_snap_nxt  = ch_mask;
                    if (ch_mask != '0) begin
                        w_ch_nxt    = w_lowest;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_start_nxt = 1'b1;
                w_to_nxt    = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the timeout cycle still counts as success.
                if (conv_done) begin
                    w_data_nxt[int'(r_conv_ch)*DATA_W +: DATA_W] = conv_data;
                    w_valid_nxt[r_conv_ch] = 1'b1;
                    w_state_nxt = S_NEXT;
                end else if (r_to_cnt == TO_LAST) begin
                    w_err_nxt              = 1'b1;
                    w_errch_nxt            = r_conv_ch;
                    w_valid_nxt[r_conv_ch] = 1'b0;
                    w_state_nxt            = S_NEXT;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_NEXT: begin
                if (w_has_above) begin
                    w_ch_nxt    = w_above;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_cnt_nxt   = r_scan_count + 8'd1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A new request in the same cycle the old one is taken stays queued.
    assign w_pend_nxt = (r_pending & ~w_pend_take) | single_scan
                        | w_period_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_period      <= '0;
            r_pending     <= 1'b0;
            r_snap        <= '0;
            r_to_cnt      <= '0;
            r_conv_start  <= 1'b0;
            r_conv_ch     <= '0;
            r_ch_data     <= '0;
            r_ch_valid    <= '0;
            r_scan_done   <= 1'b0;
            r_scan_count  <= '0;
            r_timeout_err <= 1'b0;
            r_err_ch      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_period      <= w_period_nxt;
            r_pending     <= w_pend_nxt;
            r_snap        <= w_snap_nxt;
            r_to_cnt      <= w_to_nxt;
            r_conv_start  <= w_start_nxt;
            r_conv_ch     <= w_ch_nxt;
            r_ch_data     <= w_data_nxt;
            r_ch_valid    <= w_valid_nxt;
            r_scan_done   <= w_done_nxt;
            r_scan_count  <= w_cnt_nxt;
            r_timeout_err <= w_err_nxt;
            r_err_ch      <= w_errch_nxt;
        end
    end

    assign conv_start   = r_conv_start;
    assign conv_ch      = r_conv_ch;
    assign ch_data      = r_ch_data;
    assign ch_valid     = r_ch_valid;
    assign scan_done    = r_scan_done;
    assign scan_count   = r_scan_count;
    assign busy         = (r_state != S_IDLE);
    assign scan_pending = r_pending;
    assign timeout_err  = r_timeout_err;
    assign err_ch       = r_err_ch;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Bench for adc_scan_scheduler: randomized scans against a channel-list
// model of expected order, start timing, results and error state.
module tb_adc_scan_scheduler;

    localparam int NUM_CH       = 4;
    localparam int CH_W         = 2;
    localparam int DATA_W       = 16;
    localparam int SCAN_PERIOD  = 100;
    localparam int CONV_TIMEOUT = 255;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     scan_enable = 1'b0;
    logic                     single_scan = 1'b0;
    logic [NUM_CH-1:0]        ch_mask = '0;
    logic                     err_clear = 1'b0;
    logic                     conv_start;
    logic [CH_W-1:0]          conv_ch;
    logic                     conv_done;
    logic [DATA_W-1:0]        conv_data;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic                     scan_done;
    logic [7:0]               scan_count;
    logic                     busy;
    logic                     scan_pending;
    logic                     timeout_err;
    logic [CH_W-1:0]          err_ch;

    logic              resp_done = 1'b0;
    logic [DATA_W-1:0] resp_data = '0;
    logic              man_done = 1'b0;
    logic [DATA_W-1:0] man_data = '0;

    assign conv_done = resp_done | man_done;
    assign conv_data = man_done ? man_data : resp_data;

    adc_scan_scheduler #(
        .NUM_CH      (NUM_CH),
        .CH_W        (CH_W),
        .DATA_W      (DATA_W),
        .SCAN_PERIOD (SCAN_PERIOD),
        .CONV_TIMEOUT(CONV_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_enable (scan_enable),
        .single_scan (single_scan),
        .ch_mask     (ch_mask),
        .err_clear   (err_clear),
        .conv_start  (conv_start),
        .conv_ch     (conv_ch),
        .conv_done   (conv_done),
        .conv_data   (conv_data),
        .ch_data     (ch_data),
        .ch_valid    (ch_valid),
        .scan_done   (scan_done),
        .scan_count  (scan_count),
        .busy        (busy),
        .scan_pending(scan_pending),
        .timeout_err (timeout_err),
        .err_ch      (err_ch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_done = 0;
    int st_q[$];
    int ch_q[$];

    // Conversion plan for each channel.
    logic [DATA_W-1:0] plan_data [NUM_CH];
    int                delay     [NUM_CH];
    bit                silent    [NUM_CH];

    // Reference state.
    logic [DATA_W-1:0] exp_data [NUM_CH];
    logic [NUM_CH-1:0] exp_valid;
    int                exp_count;
    logic              exp_err;
    int                exp_errch;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (scan_done) n_done <= n_done + 1;

    // Logs each conversion request and answers it per the plan.
    initial begin
        int c;
        forever begin
            @(posedge clk);
            #1;
            if (conv_start) begin
                c = int'(conv_ch);
                st_q.push_back(cyc);
                ch_q.push_back(c);
                if (!silent[c]) begin
                    if (delay[c] > 0) begin
                        repeat (delay[c]) @(posedge clk);
                        #1;
                    end
                    resp_data = plan_data[c];
                    resp_done = 1'b1;
                    @(posedge clk);
                    #1;
                    resp_done = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NUM_CH; i++) begin
            chk($sformatf("%s ch_data%0d", tag, i),
                64'(ch_data[i*DATA_W +: DATA_W]), 64'(exp_data[i]));
        end
        chk({tag, " ch_valid"}, 64'(ch_valid), 64'(exp_valid));
        chk({tag, " scan_count"}, 64'(scan_count), 64'(exp_count % 256));
        chk({tag, " timeout_err"}, 64'(timeout_err), 64'(exp_err));
        chk({tag, " err_ch"}, 64'(err_ch), 64'(exp_errch));
        chk({tag, " busy"}, 64'(busy), 64'(0));
        chk({tag, " conv_start"}, 64'(conv_start), 64'(0));
    endtask

    task automatic randomize_plan();
        for (int i = 0; i < NUM_CH; i++) begin
            plan_data[i] = DATA_W'($urandom);
            delay[i]     = int'($urandom_range(0, 6));
            silent[i]    = 1'b0;
        end
    endtask

    // One single_scan-triggered scan over mask m, checked end to end.
    task automatic do_scan(input string tag, input logic [NUM_CH-1:0] m);
        int n0, d0, k, stamp, idx;
        n0 = st_q.size();
        d0 = n_done;
        @(negedge clk);
        ch_mask     = m;
        single_scan = 1'b1;
        k           = cyc;
        @(negedge clk);
        single_scan = 1'b0;
        for (int t = 0; t < 3000 && n_done == d0; t++) @(negedge clk);
        chk({tag, " scan_done"}, 64'(n_done - d0), 64'(1));
        stamp = k + 3;
        idx   = n0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m[c]) begin
                if (idx < st_q.size()) begin
                    chk({tag, " conv_ch"}, 64'(ch_q[idx]), 64'(c));
                    chk({tag, " start_cyc"}, 64'(st_q[idx]), 64'(stamp));
                end
                idx++;
                if (silent[c]) begin
                    stamp       += CONV_TIMEOUT + 3;
                    exp_valid[c] = 1'b0;
                    exp_err      = 1'b1;
                    exp_errch    = c;
                end else begin
                    stamp       += 3 + delay[c];
                    exp_data[c]  = plan_data[c];
                    exp_valid[c] = 1'b1;
                end
            end
        end
        chk({tag, " n_starts"}, 64'(st_q.size() - n0), 64'(idx - n0));
        exp_count++;
        @(negedge clk);
        chk_regs(tag);
    endtask

    initial begin
        int n0, d0, k;
        for (int i = 0; i < NUM_CH; i++) begin
            exp_data[i]  = '0;
            plan_data[i] = '0;
            delay[i]     = 0;
            silent[i]    = 1'b0;
        end
        exp_valid = '0;
        exp_count = 0;
        exp_err   = 1'b0;
        exp_errch = 0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk_regs("reset");
        chk("reset scan_done", 64'(scan_done), 64'(0));
        chk("reset pending", 64'(scan_pending), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Mask 1011, every conversion answered after 3 cycles.
        randomize_plan();
        for (int i = 0; i < NUM_CH; i++) delay[i] = 3;
        do_scan("t1", 4'b1011);
        chk("t1 valid_lit", 64'(ch_valid), 64'(4'b1011));
        chk("t1 count_lit", 64'(scan_count), 64'(1));

        // Random masks, delays and data.
        repeat (6) begin
            randomize_plan();
            do_scan("rand", NUM_CH'($urandom_range(1, 15)));
        end

        // Channel 2 never answers.
        randomize_plan();
        silent[2] = 1'b1;
        do_scan("t3", 4'b1111);
        chk("t3 err_lit", 64'(timeout_err), 64'(1));
        chk("t3 errch_lit", 64'(err_ch), 64'(2));
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        exp_err   = 1'b0;
        chk("t3 err_clear", 64'(timeout_err), 64'(0));
        silent[2] = 1'b0;

        // Three requests during a busy scan merge into one extra scan.
        randomize_plan();
        for (int i = 0; i < NUM_CH; i++) delay[i] = 5;
        n0 = st_q.size();
        d0 = n_done;
        @(negedge clk);
        ch_mask     = 4'b1111;
        single_scan = 1'b1;
        @(negedge clk);
        single_scan = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4 busy", 64'(busy), 64'(1));
        repeat (3) begin
            single_scan = 1'b1;
            @(negedge clk);
            single_scan = 1'b0;
            @(negedge clk);
        end
        chk("t4 pending", 64'(scan_pending), 64'(1));
        for (int t = 0; t < 3000 && n_done < d0 + 2; t++) @(negedge clk);
        repeat (60) @(negedge clk);
        chk("t4 scans", 64'(n_done - d0), 64'(2));
        chk("t4 n_starts", 64'(st_q.size() - n0), 64'(8));
        for (int j = 0; j < 8; j++) begin
            if (n0 + j < st_q.size())
                chk("t4 conv_ch", 64'(ch_q[n0+j]), 64'(j % 4));
        end
        for (int i = 0; i < NUM_CH; i++) begin
            exp_data[i]  = plan_data[i];
            exp_valid[i] = 1'b1;
        end
        exp_count += 2;
        chk_regs("t4");

        // Periodic scanning, then disabled mid-scan.
        randomize_plan();
        delay[0] = 0;
        n0 = st_q.size();
        d0 = n_done;
        @(negedge clk);
        ch_mask     = 4'b0001;
        scan_enable = 1'b1;
        k           = cyc;
        for (int t = 0; t < 500 && st_q.size() < n0 + 3; t++)
            @(negedge clk);
        scan_enable = 1'b0;
        repeat (300) @(negedge clk);
        chk("t2 n_starts", 64'(st_q.size() - n0), 64'(3));
        for (int j = 0; j < 3; j++) begin
            if (n0 + j < st_q.size())
                chk("t2 start_cyc", 64'(st_q[n0+j]),
                    64'(k + SCAN_PERIOD + 2 + j * SCAN_PERIOD));
        end
        chk("t2 scans", 64'(n_done - d0), 64'(3));
        exp_data[0]  = plan_data[0];
        exp_valid[0] = 1'b1;
        exp_count   += 3;
        chk_regs("t2");

        // Empty mask: request is consumed with no activity.
        n0 = st_q.size();
        d0 = n_done;
        @(negedge clk);
        ch_mask     = '0;
        single_scan = 1'b1;
        @(negedge clk);
        single_scan = 1'b0;
        chk("t5 pending_set", 64'(scan_pending), 64'(1));
        @(negedge clk);
        chk("t5 pending_clr", 64'(scan_pending), 64'(0));
        chk("t5 busy", 64'(busy), 64'(0));
        repeat (20) @(negedge clk);
        chk("t5 n_starts", 64'(st_q.size() - n0), 64'(0));
        chk("t5 scans", 64'(n_done - d0), 64'(0));
        chk_regs("t5");

        // Reset while waiting, then a stray completion.
        randomize_plan();
        silent[0] = 1'b1;
        n0 = st_q.size();
        @(negedge clk);
        ch_mask     = 4'b0001;
        single_scan = 1'b1;
        @(negedge clk);
        single_scan = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6 busy_before", 64'(busy), 64'(1));
        chk("t6 n_starts", 64'(st_q.size() - n0), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        man_data = 16'hBEEF;
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) exp_data[i] = '0;
        exp_valid = '0;
        exp_count = 0;
        exp_err   = 1'b0;
        exp_errch = 0;
        chk_regs("t6");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
